// File: rtl/scan_decoder.sv
// Registered N-to-2^N line decoder with a built-in scan/sweep sequencer and per-line dwell.
// Latency: cur_sel updates on the edge after its cause; y follows cur_sel one edge later.
// Backpressure: none; the 138-style enable freezes the sequencer and blanks y instead.
module scan_decoder #(
    parameter int SEL_W      = 3,
    parameter int DWELL_W    = 16,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    g1,
    input  logic                    g2a_n,
    input  logic                    g2b_n,
    input  logic [1:0]              mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [DWELL_W-1:0]      dwell,
    input  logic                    start,
    output logic [(1<<SEL_W)-1:0]   y,
    output logic [SEL_W-1:0]        cur_sel,
    output logic                    busy,
    output logic                    sweep_done
);
    localparam int NOUT = 1 << SEL_W;
    localparam logic [NOUT-1:0] Y_OFF = (ACTIVE_LOW != 0) ? {NOUT{1'b1}} : {NOUT{1'b0}};

    localparam logic [1:0] M_DIRECT = 2'b00;
    localparam logic [1:0] M_SCAN   = 2'b01;
    localparam logic [1:0] M_SWEEP  = 2'b10;

    typedef enum logic [1:0] {IDLE, SCAN, SWEEP, DONE} state_t;

    state_t              state;
    logic [1:0]          mode_q;
    logic [DWELL_W-1:0]  dcnt;
    logic [DWELL_W-1:0]  dwell_q;
    logic                en;
    logic                line_end;
    logic                last_line;
    logic                show;
    logic [NOUT-1:0]     y_nxt;

    function automatic logic [NOUT-1:0] decode(input logic [SEL_W-1:0] s);
        logic [NOUT-1:0] oh;
        oh    = '0;
        oh[s] = 1'b1;
        return (ACTIVE_LOW != 0) ? ~oh : oh;
    endfunction

    // dwell_q holds the dwell in force for the current line, so a mid-line
    // change to the dwell input only affects the following line.
    always_comb begin
        en        = g1 & ~g2a_n & ~g2b_n;
        line_end  = (dcnt == dwell_q);
        last_line = &cur_sel;
        show      = en && !(mode_q == M_SWEEP && state != SWEEP);
        y_nxt     = show ? decode(cur_sel) : Y_OFF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mode_q     <= M_DIRECT;
            dcnt       <= '0;
            dwell_q    <= '0;
            cur_sel    <= '0;
            busy       <= 1'b0;
            sweep_done <= 1'b0;
            y          <= Y_OFF;
        end else begin
            mode_q <= mode;
            y      <= y_nxt;
            if (mode != mode_q) begin
                state      <= IDLE;
                cur_sel    <= '0;
                dcnt       <= '0;
                dwell_q    <= dwell;
                busy       <= 1'b0;
                sweep_done <= 1'b0;
            end else if (en) begin
                sweep_done <= 1'b0;
                case (mode_q)
                    M_DIRECT: begin
                        state   <= IDLE;
                        cur_sel <= sel;
                    end
                    M_SCAN: begin
                        state <= SCAN;
                        if (line_end) begin
                            dcnt    <= '0;
                            dwell_q <= dwell;
                            cur_sel <= cur_sel + SEL_W'(1);
                        end else begin
                            dcnt <= dcnt + DWELL_W'(1);
                        end
                    end
                    M_SWEEP: begin
                        case (state)
                            SWEEP: begin
                                if (line_end) begin
                                    dcnt    <= '0;
                                    dwell_q <= dwell;
                                    if (last_line) begin
                                        state      <= DONE;
                                        busy       <= 1'b0;
                                        sweep_done <= 1'b1;
                                        cur_sel    <= '0;
                                    end else begin
                                        cur_sel <= cur_sel + SEL_W'(1);
                                    end
                                end else begin
                                    dcnt <= dcnt + DWELL_W'(1);
                                end
                            end
                            DONE: state <= IDLE;
                            default: begin
                                if (start) begin
                                    state   <= SWEEP;
                                    busy    <= 1'b1;
                                    cur_sel <= '0;
                                    dcnt    <= '0;
                                    dwell_q <= dwell;
                                end
                            end
                        endcase
                    end
                    default: ;  // hold: park on the current line
                endcase
            end
        end
    end
endmodule

// File: tb/tb_scan_decoder.sv
// Bench for scan_decoder: an 8-line active-low and a 16-line active-high instance share stimulus.
module tb_scan_decoder;
    logic        clk = 1'b0;
    logic        rst_n, g1, g2a_n, g2b_n, start;
    logic [1:0]  mode;
    logic [3:0]  sel;
    logic [15:0] dwell;

    logic [7:0]  y3;
    logic [2:0]  cs3;
    logic        b3, d3;
    logic [15:0] y4;
    logic [3:0]  cs4;
    logic        b4, d4;

    always #5 clk = ~clk;

    scan_decoder #(.SEL_W(3), .DWELL_W(16), .ACTIVE_LOW(1)) u3 (
        .clk(clk), .rst_n(rst_n), .g1(g1), .g2a_n(g2a_n), .g2b_n(g2b_n),
        .mode(mode), .sel(sel[2:0]), .dwell(dwell), .start(start),
        .y(y3), .cur_sel(cs3), .busy(b3), .sweep_done(d3));

    scan_decoder #(.SEL_W(4), .DWELL_W(16), .ACTIVE_LOW(0)) u4 (
        .clk(clk), .rst_n(rst_n), .g1(g1), .g2a_n(g2a_n), .g2b_n(g2b_n),
        .mode(mode), .sel(sel), .dwell(dwell), .start(start),
        .y(y4), .cur_sel(cs4), .busy(b4), .sweep_done(d4));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: per instance, which line is lit, how long it has been lit, and the sweep activity.
    localparam int A_QUIET = 0, A_SCAN = 1, A_SWEEP = 2, A_FIN = 3;
    int          nl [2] = '{8, 16};
    bit          al [2] = '{1'b1, 1'b0};
    int          m_line [2] = '{0, 0};
    int          m_tick [2] = '{0, 0};
    int          m_hold [2] = '{0, 0};
    int          m_act  [2] = '{A_QUIET, A_QUIET};
    bit          m_busy [2] = '{1'b0, 1'b0};
    bit          m_pulse[2] = '{1'b0, 1'b0};
    logic [1:0]  m_mode [2] = '{2'd0, 2'd0};
    logic [15:0] m_y    [2] = '{16'h00FF, 16'h0000};

    function automatic logic [15:0] pat(input int i, input int line, input bit lit);
        logic [15:0] mask, oh;
        mask = (nl[i] == 16) ? 16'hFFFF : ((16'h1 << nl[i]) - 16'h1);
        oh   = lit ? (16'h1 << line) : 16'h0;
        return al[i] ? (~oh & mask) : oh;
    endfunction

    task automatic mreset(input int i);
        m_line[i] = 0; m_tick[i] = 0; m_hold[i] = 0; m_act[i] = A_QUIET;
        m_busy[i] = 0; m_pulse[i] = 0; m_mode[i] = 2'd0; m_y[i] = pat(i, 0, 1'b0);
    endtask

    task automatic adv(input int i, input bit sweeping);
        if (m_tick[i] == m_hold[i]) begin
            m_tick[i] = 0;
            m_hold[i] = int'(dwell);
            if (sweeping && m_line[i] == nl[i] - 1) begin
                m_act[i] = A_FIN; m_busy[i] = 0; m_pulse[i] = 1; m_line[i] = 0;
            end else begin
                m_line[i] = (m_line[i] + 1) % nl[i];
            end
        end else begin
            m_tick[i]++;
        end
    endtask

    task automatic mstep(input int i);
        bit en, lit;
        logic [15:0] ny;
        en  = g1 && !g2a_n && !g2b_n;
        lit = en && !(m_mode[i] == 2'd2 && m_act[i] != A_SWEEP);
        ny  = pat(i, m_line[i], lit);
        if (mode !== m_mode[i]) begin
            m_act[i] = A_QUIET; m_line[i] = 0; m_tick[i] = 0;
            m_busy[i] = 0; m_pulse[i] = 0; m_hold[i] = int'(dwell);
        end else if (en) begin
            m_pulse[i] = 0;
            case (m_mode[i])
                2'd0: begin m_act[i] = A_QUIET; m_line[i] = int'(sel) % nl[i]; end
                2'd1: begin m_act[i] = A_SCAN; adv(i, 1'b0); end
                2'd2: begin
                    if (m_act[i] == A_SWEEP) adv(i, 1'b1);
                    else if (m_act[i] == A_FIN) m_act[i] = A_QUIET;
                    else if (start) begin
                        m_act[i] = A_SWEEP; m_busy[i] = 1; m_line[i] = 0;
                        m_tick[i] = 0; m_hold[i] = int'(dwell);
                    end
                end
                default: ;
            endcase
        end
        m_mode[i] = mode;
        m_y[i]    = ny;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) mreset(i);
        end else begin
            for (int i = 0; i < 2; i++) mstep(i);
        end
    end

    always @(negedge clk) begin
        chk("y8",     {24'h0, y3},  {24'h0, m_y[0][7:0]});
        chk("sel8",   {29'h0, cs3}, 32'(m_line[0]));
        chk("busy8",  {31'h0, b3},  {31'h0, m_busy[0]});
        chk("done8",  {31'h0, d3},  {31'h0, m_pulse[0]});
        chk("y16",    {16'h0, y4},  {16'h0, m_y[1]});
        chk("sel16",  {28'h0, cs4}, 32'(m_line[1]));
        chk("busy16", {31'h0, b4},  {31'h0, m_busy[1]});
        chk("done16", {31'h0, d4},  {31'h0, m_pulse[1]});
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_cs3(input logic [2:0] v);
        for (int k = 0; k < 100 && cs3 !== v; k++) step();
        chk("reach_line", {29'h0, cs3}, {29'h0, v});
    endtask

    int nb, nd;
    bit prev;

    initial begin
        rst_n = 1'b1; g1 = 1'b1; g2a_n = 1'b0; g2b_n = 1'b0;
        mode = 2'b00; sel = 4'd5; dwell = 16'd0; start = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_y8", {24'h0, y3}, 32'hFF);
        chk("rst_y16", {16'h0, y4}, 32'h0);
        chk("rst_busy", {31'h0, b3}, 32'h0);
        #20;
        @(posedge clk); #2 rst_n = 1'b1;

        // direct mode
        step();
        chk("direct_sel", {29'h0, cs3}, 32'd5);
        step();
        chk("direct_y", {24'h0, y3}, 32'hDF);

        // enable gating, one enable input at a time
        sel = 4'd2;
        step(); step();
        for (int c = 0; c < 3; c++) begin
            g1 = (c != 0); g2a_n = (c == 1); g2b_n = (c == 2);
            step();
            chk("gate_off_y", {24'h0, y3}, 32'hFF);
            chk("gate_off_sel", {29'h0, cs3}, 32'd2);
            g1 = 1'b1; g2a_n = 1'b0; g2b_n = 1'b0;
            step();
            chk("gate_on_y", {24'h0, y3}, 32'hFB);
        end

        // continuous scan, dwell 2, then dwell 0 from mid-line
        mode = 2'b01; dwell = 16'd2;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (k == 3)  chk("scan_k3",  {29'h0, cs3}, 32'd0);
            if (k == 4)  chk("scan_k4",  {29'h0, cs3}, 32'd1);
            if (k == 5)  chk("scan_y8",  {24'h0, y3},  32'hFD);
            if (k == 5)  chk("scan_y16", {16'h0, y4},  32'h0002);
            if (k == 22) chk("scan_k22", {29'h0, cs3}, 32'd7);
            if (k == 25) chk("scan_wrap", {29'h0, cs3}, 32'd0);
            if (k == 25) chk("scan_16_k25", {28'h0, cs4}, 32'd8);
            if (k == 26) dwell = 16'd0;
            if (k == 27) chk("dwchg_k27", {29'h0, cs3}, 32'd0);
            if (k == 28) chk("dwchg_k28", {29'h0, cs3}, 32'd1);
            if (k == 29) chk("dwchg_k29", {29'h0, cs3}, 32'd2);
            if (k == 30) chk("dwchg_k30", {29'h0, cs3}, 32'd3);
        end

        // single sweep, dwell 1, with an ignored second start
        mode = 2'b10; dwell = 16'd1;
        step();
        start = 1'b1; step(); start = 1'b0;
        chk("sweep_busy", {31'h0, b3}, 32'd1);
        nb = 1; nd = 0; prev = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            start = (i == 5);
            step();
            if (prev) chk("sweep_y_after", {24'h0, y3}, 32'hFF);
            prev = d3;
            nb += int'(b3);
            nd += int'(d3);
        end
        start = 1'b0;
        chk("sweep_busy_cycles", 32'(nb), 32'd16);
        chk("sweep_done_count", 32'(nd), 32'd1);

        // freeze mid-sweep and resume
        start = 1'b1; step(); start = 1'b0;
        wait_cs3(3'd4);
        g1 = 1'b0;
        repeat (5) step();
        chk("frz_y", {24'h0, y3}, 32'hFF);
        chk("frz_sel", {29'h0, cs3}, 32'd4);
        chk("frz_busy", {31'h0, b3}, 32'd1);
        g1 = 1'b1;
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            nd += int'(d3);
        end
        chk("frz_done_count", 32'(nd), 32'd1);

        // asynchronous reset mid-sweep
        start = 1'b1; step(); start = 1'b0;
        wait_cs3(3'd3);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_y8", {24'h0, y3}, 32'hFF);
        chk("arst_y16", {16'h0, y4}, 32'h0);
        chk("arst_busy", {31'h0, b3}, 32'd0);
        chk("arst_sel", {29'h0, cs3}, 32'd0);
        step(); step();
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            nd += int'(d3) + int'(d4);
        end
        chk("arst_no_done", 32'(nd), 32'd0);

        // hold parks on line 0
        mode = 2'b11; sel = 4'd6;
        step(); step();
        chk("hold_y8", {24'h0, y3}, 32'hFE);
        chk("hold_y16", {16'h0, y4}, 32'h0001);
        chk("hold_sel", {29'h0, cs3}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
